fru_filter_config_loader: RTL and testbench
===========================================

# fru_filter_config_loader

Serial configuration loader that produces the `BypassEn` / `RegConst` control vectors consumed by the signal filter unit. It receives a start-framed, parity-protected serial bitstream through a valid/ready handshake and shifts it into shadow registers. The frame is committed atomically to the filter-facing outputs only when the frame completes and the parity check passes. It sits between the patch configuration fabric and the signal filter unit, one instance per filter.

## Interface
Parameters:
- `FILTER_SIZE`, default 10: width of the controlled signal vector; a frame carries 2*FILTER_SIZE+1 bits.

Ports:
- `Clk`  in  1: single clock. All logic is on the rising edge.
- `Rst`  in  1: reset; synchronous, active-high.
- `CfgStart`  in  1: one-cycle frame-start pulse.
- `CfgValid`  in  1: `CfgData` holds a valid bit.
- `CfgData`  in  1: serial configuration bit.
- `CfgReady`  out  1: the loader accepts a bit this cycle.
- `ClearBypass`  in  1: synchronous emergency clear of `BypassEn`.
- `BypassEn`  out  FILTER_SIZE: per-bit override select, to the filter.
- `RegConst`  out  FILTER_SIZE: per-bit override constant, to the filter.
- `CfgDone`  out  1: one-cycle pulse; a frame was committed.
- `CfgError`  out  1: one-cycle pulse; a frame was discarded on parity failure.

## Operation
- States: IDLE, SHIFT, COMMIT.
- A bit is accepted on any cycle where `CfgValid & CfgReady`.
- `CfgReady` is 1 only in SHIFT. In IDLE or COMMIT, `CfgValid` is ignored and the bit is dropped.
- IDLE to SHIFT on `CfgStart`. This clears the bit counter, the shadow registers and the running parity.
- In SHIFT, accepted bit index i, counting from 0:
  - i in 0..N-1 goes to shadow `RegConst[i]`.
  - i in N..2N-1 goes to shadow `BypassEn[i-N]`.
  - i = 2N is the parity bit.
- Parity is even: the XOR of all 2N+1 bits must be 0.
- SHIFT to COMMIT on acceptance of bit 2N.
- `CfgStart` in SHIFT restarts the frame: the counter and shadows are cleared and the state stays SHIFT. If a bit is accepted in the same cycle, `CfgStart` wins and the bit is dropped.
- `CfgStart` in COMMIT is ignored.
- COMMIT lasts exactly 1 cycle, then goes to IDLE.
  - Parity OK: shadows load into `BypassEn` / `RegConst` and `CfgDone` is 1 in the following cycle.
  - Parity bad: the outputs hold their old values and `CfgError` is 1 in the following cycle.
- `ClearBypass` forces `BypassEn` to 0 at the next edge in any state. If a commit happens in the same cycle, the clear wins and `BypassEn` is 0. `RegConst` still commits and `CfgDone` still pulses.
- The bit counter is $clog2(2N+1) bits wide. It never exceeds 2N; there is no wrap-around.
- `Rst` during SHIFT or COMMIT aborts the frame. No pulse is produced.

## Timing
- Reset values:
  - `BypassEn` = 0 (pass-through, safe) and `RegConst` = 0.
  - `CfgReady` = 0, `CfgDone` = 0, `CfgError` = 0.
  - State IDLE, counter 0.
- `CfgStart` sampled at edge t: `CfgReady` = 1 from cycle t+1.
- `CfgReady` is registered; it depends only on state, not on `CfgValid`.
- Parity bit accepted at edge k:
  - COMMIT during cycle k+1, with `CfgReady` = 0.
  - New outputs and the `CfgDone` / `CfgError` pulse visible during cycle k+2.
  - Back in IDLE at k+2.
- Minimum frame: 1 + (2N+1) + 1 cycles from `CfgStart` to visible outputs.
- Stalls (`CfgValid` = 0) are unbounded and have no timeout.
- Outputs never change mid-frame. They change only at the COMMIT edge or on `ClearBypass`.

## Structure
- Package `fru_pkg`:
  - typedef enum for loader states.
  - Frame-length helper function 2*FILTER_SIZE+1.
- Single module; no sub-module.
- The shadow registers and parity accumulator are local.

## Test plan
Each scenario uses N=4. Bit sequences are listed in transmission order, bit 0 first.
- Reset then idle: all outputs 0. `CfgValid` pulses in IDLE produce `CfgReady` = 0 and no output change.
- Good frame: `CfgStart`, then 0,1,0,1, 1,1,0,0, parity 0. Response: `RegConst` = 4'b1010, `BypassEn` = 4'b0011, and `CfgDone` pulses exactly 2 cycles after the parity bit.
- Bad parity: the same frame with parity 1. Response: outputs unchanged from the previous values and `CfgError` pulses for one cycle.
- Restart: `CfgStart` after 3 bits, then a full good frame. Response: only the second frame commits, with correct values.
- Simultaneous events:
  - `ClearBypass` in the COMMIT cycle of a good frame: `BypassEn` = 0, `RegConst` = 4'b1010, `CfgDone` = 1.
  - `ClearBypass` alone while `BypassEn` = 4'b0011: `BypassEn` = 0 the next cycle.
- Stall and reset: random `CfgValid` gaps still commit the correct values. `Rst` asserted mid-SHIFT returns all outputs to 0 with no `CfgDone`.

Source files
------------

// File: rtl/fru_pkg.sv
// Shared types and helpers for the filter configuration loader.
package fru_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } loader_state_t;

    // Data bits for RegConst and BypassEn, plus one even-parity bit.
    function automatic int frame_len(input int filter_size);
        return 2 * filter_size + 1;
    endfunction

endpackage

// File: rtl/fru_filter_config_loader.sv
// Serial loader for the filter BypassEn/RegConst vectors. Frames are shifted into
// shadow registers and committed atomically only when even parity checks out.
module fru_filter_config_loader
    import fru_pkg::*;
#(
    parameter int FILTER_SIZE = 10
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   CfgStart,
    input  logic                   CfgValid,
    input  logic                   CfgData,
    output logic                   CfgReady,
    input  logic                   ClearBypass,
    output logic [FILTER_SIZE-1:0] BypassEn,
    output logic [FILTER_SIZE-1:0] RegConst,
    output logic                   CfgDone,
    output logic                   CfgError
);

    localparam int FRAME_LEN = frame_len(FILTER_SIZE);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    loader_state_t          state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [FILTER_SIZE-1:0] shadow_const_reg;
    logic [FILTER_SIZE-1:0] shadow_bypass_reg;
    logic                   parity_reg;
    logic                   ready_reg;
    logic                   done_reg;
    logic                   error_reg;
    logic [FILTER_SIZE-1:0] const_reg;
    logic [FILTER_SIZE-1:0] bypass_reg;

    // A start pulse takes priority over a data bit arriving in the same cycle.
    logic                   accept;
    logic [FILTER_SIZE-1:0] const_wr;
    logic [FILTER_SIZE-1:0] bypass_wr;

    assign accept = ready_reg & CfgValid & ~CfgStart;

    generate
        for (genvar gi = 0; gi < FILTER_SIZE; gi++) begin : g_decode
            assign const_wr[gi]  = accept && (cnt_reg == CNT_W'(gi));
            assign bypass_wr[gi] = accept && (cnt_reg == CNT_W'(gi + FILTER_SIZE));
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg         <= ST_IDLE;
            cnt_reg           <= '0;
            shadow_const_reg  <= '0;
            shadow_bypass_reg <= '0;
            parity_reg        <= 1'b0;
            ready_reg         <= 1'b0;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
            const_reg         <= '0;
            bypass_reg        <= '0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (CfgStart) begin
                        state_reg         <= ST_SHIFT;
                        ready_reg         <= 1'b1;
                        cnt_reg           <= '0;
                        shadow_const_reg  <= '0;
                        shadow_bypass_reg <= '0;
                        parity_reg        <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (CfgStart) begin
                        cnt_reg           <= '0;
                        shadow_const_reg  <= '0;
                        shadow_bypass_reg <= '0;
                        parity_reg        <= 1'b0;
                    end else if (accept) begin
                        parity_reg <= parity_reg ^ CfgData;
                        for (int i = 0; i < FILTER_SIZE; i++) begin
                            if (const_wr[i])  shadow_const_reg[i]  <= CfgData;
                            if (bypass_wr[i]) shadow_bypass_reg[i] <= CfgData;
                        end
                        // The counter parks on the parity index; it never wraps.
                        if (cnt_reg == LAST_IDX) begin
                            state_reg <= ST_COMMIT;
                            ready_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end

                ST_COMMIT: begin
                    state_reg <= ST_IDLE;
                    if (!parity_reg) begin
                        const_reg  <= shadow_const_reg;
                        bypass_reg <= shadow_bypass_reg;
                        done_reg   <= 1'b1;
                    end else begin
                        error_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b0;
                end
            endcase

            // Emergency clear overrides any commit landing on the same edge.
            if (ClearBypass) begin
                bypass_reg <= '0;
            end
        end
    end

    assign CfgReady = ready_reg;
    assign BypassEn = bypass_reg;
    assign RegConst = const_reg;
    assign CfgDone  = done_reg;
    assign CfgError = error_reg;

endmodule

// File: tb/tb_fru_filter_config_loader.sv
// Scoreboard bench for the filter configuration loader with FILTER_SIZE = 4.
module tb_fru_filter_config_loader;

    localparam int N  = 4;
    localparam int FL = 2 * N + 1;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         CfgStart;
    logic         CfgValid;
    logic         CfgData;
    logic         CfgReady;
    logic         ClearBypass;
    logic [N-1:0] BypassEn;
    logic [N-1:0] RegConst;
    logic         CfgDone;
    logic         CfgError;

    fru_filter_config_loader #(.FILTER_SIZE(N)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .CfgStart    (CfgStart),
        .CfgValid    (CfgValid),
        .CfgData     (CfgData),
        .CfgReady    (CfgReady),
        .ClearBypass (ClearBypass),
        .BypassEn    (BypassEn),
        .RegConst    (RegConst),
        .CfgDone     (CfgDone),
        .CfgError    (CfgError)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit           is_done;
        logic [N-1:0] rc;
        logic [N-1:0] be;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [N-1:0] exp_const  = '0;
    logic [N-1:0] exp_bypass = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", tag, obs, $time);
        end
    endtask

    // Every done/error pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge Clk) begin
        if (!Rst && (CfgDone || CfgError)) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_pulse", {30'd0, CfgDone, CfgError}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("pulse_kind", {30'd0, CfgDone, CfgError}, mon_e.is_done ? 32'd2 : 32'd1);
                check_val("regconst", 32'(RegConst), 32'(mon_e.rc));
                check_val("bypassen", 32'(BypassEn), 32'(mon_e.be));
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic send_bit(input logic b);
        bit r;
        int waited;
        CfgValid = 1'b1;
        CfgData  = b;
        waited   = 0;
        do begin
            @(negedge Clk);
            r = CfgReady;
            step();
            waited++;
        end while (!r && waited < 50);
        if (!r) check_val("accept_timeout", 32'd0, 32'd1);
        CfgValid = 1'b0;
        CfgData  = 1'b0;
    endtask

    task automatic pulse_start();
        CfgStart = 1'b1;
        step();
        CfgStart = 1'b0;
        @(negedge Clk);
        check_val("ready_after_start", 32'(CfgReady), 32'd1);
        step();
    endtask

    task automatic send_frame(input logic [FL-1:0] bits, input bit clr, input int max_gap);
        logic ok;
        exp_t e;
        ok = ~^bits;
        for (int i = 0; i < FL; i++) begin
            if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
            if (i == FL - 1) begin
                if (ok) begin
                    exp_const  = bits[N-1:0];
                    exp_bypass = bits[2*N-1:N];
                end
                if (clr) exp_bypass = '0;
                e.is_done = ok;
                e.rc      = exp_const;
                e.be      = exp_bypass;
                sb_q.push_back(e);
            end
            send_bit(bits[i]);
        end
        if (clr) ClearBypass = 1'b1;
        @(negedge Clk);
        check_val("commit_ready", 32'(CfgReady), 32'd0);
        check_val("commit_no_pulse", {30'd0, CfgDone, CfgError}, 32'd0);
        step();
        ClearBypass = 1'b0;
        @(negedge Clk);
        check_val("done_at_k2", 32'(CfgDone), 32'(ok));
        check_val("error_at_k2", 32'(CfgError), 32'(!ok));
        check_val("idle_ready", 32'(CfgReady), 32'd0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [FL-1:0] bits;
        Rst = 1'b1; CfgStart = 1'b0; CfgValid = 1'b0; CfgData = 1'b0; ClearBypass = 1'b0;
        idle_cycles(3);
        Rst = 1'b0;
        @(negedge Clk);
        check_val("rst_bypass", 32'(BypassEn), 32'd0);
        check_val("rst_const", 32'(RegConst), 32'd0);
        check_val("rst_ready", 32'(CfgReady), 32'd0);
        check_val("rst_pulses", {30'd0, CfgDone, CfgError}, 32'd0);
        step();

        // Data offered while idle is dropped.
        CfgValid = 1'b1;
        CfgData  = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            check_val("idle_ready", 32'(CfgReady), 32'd0);
            check_val("idle_const", 32'(RegConst), 32'd0);
            step();
        end
        CfgValid = 1'b0;
        CfgData  = 1'b0;

        // Good frame: 0,1,0,1, 1,1,0,0, parity 0.
        pulse_start();
        send_frame(9'b0_0011_1010, 1'b0, 0);
        check_val("good_const", 32'(RegConst), 32'hA);
        check_val("good_bypass", 32'(BypassEn), 32'h3);

        // Same frame with parity 1 is discarded.
        pulse_start();
        send_frame(9'b1_0011_1010, 1'b0, 0);
        check_val("bad_const_hold", 32'(RegConst), 32'hA);
        check_val("bad_bypass_hold", 32'(BypassEn), 32'h3);

        // Restart after three bits; only the second frame commits.
        pulse_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        pulse_start();
        send_frame(9'b0_1010_0011, 1'b0, 0);
        check_val("restart_const", 32'(RegConst), 32'h3);
        check_val("restart_bypass", 32'(BypassEn), 32'hA);

        // Clear in the commit cycle: bypass cleared, const still commits.
        pulse_start();
        send_frame(9'b0_0011_1010, 1'b1, 0);
        check_val("clrcommit_bypass", 32'(BypassEn), 32'h0);
        check_val("clrcommit_const", 32'(RegConst), 32'hA);

        // Clear on its own.
        pulse_start();
        send_frame(9'b0_0011_1010, 1'b0, 0);
        ClearBypass = 1'b1;
        step();
        ClearBypass = 1'b0;
        exp_bypass  = '0;
        @(negedge Clk);
        check_val("clear_bypass", 32'(BypassEn), 32'h0);
        check_val("clear_const_kept", 32'(RegConst), 32'hA);
        step();

        // Random frames with stalls; odd frames carry random parity.
        for (int f = 0; f < 6; f++) begin
            bits = FL'($urandom);
            if (f % 2 == 0) bits[FL-1] = ^bits[FL-2:0];
            pulse_start();
            send_frame(bits, 1'b0, 3);
            check_val("stall_const", 32'(RegConst), 32'(exp_const));
            check_val("stall_bypass", 32'(BypassEn), 32'(exp_bypass));
        end

        // Reset mid-frame aborts it silently.
        pulse_start();
        send_frame(9'b0_0011_1010, 1'b0, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        Rst = 1'b1;
        step();
        Rst        = 1'b0;
        exp_const  = '0;
        exp_bypass = '0;
        @(negedge Clk);
        check_val("midrst_bypass", 32'(BypassEn), 32'h0);
        check_val("midrst_const", 32'(RegConst), 32'h0);
        check_val("midrst_ready", 32'(CfgReady), 32'd0);
        step();
        idle_cycles(15);

        check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
